// File: rtl/bist_controller.sv
// BIST session sequencer for the lfsr -> CUT -> misr chain: seeds and clears the
// chain, runs NPAT patterns, freezes the MISR and grades the final signature.
module bist_controller #(
  parameter int              WIDTH  = 4,
  parameter int              NPAT   = 15,
  parameter logic [WIDTH-1:0] SEED   = 4'b0001,
  parameter logic [WIDTH-1:0] GOLDEN = 4'h0
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic [WIDTH-1:0] lfsr_out,
  input  logic [WIDTH-1:0] signature,
  output logic [WIDTH-1:0] lfsr_seed,
  output logic             lfsr_clr,
  output logic             misr_clr,
  output logic             misr_finish,
  output logic             busy,
  output logic             done,
  output logic             pass,
  output logic             lock_err,
  output logic [WIDTH-1:0] pat_cnt,
  output logic [2:0]       dbg_state
);

  typedef enum logic [2:0] {
    S_IDLE    = 3'd0,
    S_INIT    = 3'd1,
    S_RUN     = 3'd2,
    S_FREEZE  = 3'd3,
    S_COMPARE = 3'd4,
    S_DONE    = 3'd5
  } state_t;

  localparam logic [WIDTH-1:0] NPAT_W   = WIDTH'(NPAT);
  localparam logic [WIDTH-1:0] LAST_CNT = WIDTH'(NPAT - 1);

  state_t           r_state;
  logic             r_lfsr_clr;
  logic             r_misr_clr;
  logic             r_misr_finish;
  logic             r_busy;
  logic             r_done;
  logic             r_pass;
  logic             r_lock_err;
  logic [WIDTH-1:0] r_pat_cnt;
  logic             w_lock;
  logic             w_sig_ok;

  assign w_lock   = (lfsr_out == '0);
  assign w_sig_ok = (signature == GOLDEN);

  // start is a level, sampled only in IDLE or DONE; there is no ready/ack, so
  // a start seen in any busy state is dropped and never queued.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_state       <= S_IDLE;
      r_lfsr_clr    <= 1'b0;
      r_misr_clr    <= 1'b0;
      r_misr_finish <= 1'b0;
      r_busy        <= 1'b0;
      r_done        <= 1'b0;
      r_pass        <= 1'b0;
      r_lock_err    <= 1'b0;
      r_pat_cnt     <= '0;
    end else begin
      case (r_state)
        S_IDLE, S_DONE: begin
          if (start) begin
            r_state       <= S_INIT;
            r_lfsr_clr    <= 1'b1;
            r_misr_clr    <= 1'b1;
            r_misr_finish <= 1'b0;
            r_busy        <= 1'b1;
            r_done        <= 1'b0;
            r_pass        <= 1'b0;
            r_lock_err    <= 1'b0;
            r_pat_cnt     <= '0;
          end
        end
        S_INIT: begin
          r_state    <= S_RUN;
          r_lfsr_clr <= 1'b0;
          r_misr_clr <= 1'b0;
        end
        S_RUN: begin
          if (r_pat_cnt != NPAT_W) begin
            r_pat_cnt <= r_pat_cnt + WIDTH'(1);
          end
          if (w_lock) begin
            r_lock_err <= 1'b1;
          end
          // The cycle that reaches NPAT (or sees a lock-up) still compacts.
          if (w_lock || (r_pat_cnt == LAST_CNT)) begin
            r_state       <= S_FREEZE;
            r_misr_finish <= 1'b1;
          end
        end
        S_FREEZE: begin
          r_state <= S_COMPARE;
        end
        S_COMPARE: begin
          r_state <= S_DONE;
          r_pass  <= w_sig_ok && !r_lock_err;
          r_busy  <= 1'b0;
          r_done  <= 1'b1;
        end
        default: begin
          r_state <= S_IDLE;
        end
      endcase
    end
  end

  assign lfsr_seed   = SEED;
  assign lfsr_clr    = r_lfsr_clr;
  assign misr_clr    = r_misr_clr;
  assign misr_finish = r_misr_finish;
  assign busy        = r_busy;
  assign done        = r_done;
  assign pass        = r_pass;
  assign lock_err    = r_lock_err;
  assign pat_cnt     = r_pat_cnt;
  assign dbg_state   = r_state;

endmodule
